// File: rtl/conditional_modulus_subtractor.sv
// Purpose : conditional final subtraction (x >= m ? x - m : x) on a word-serial big number, LSW first.
// Latency : first result word 2 cycles after the last input word is accepted; NUM_WORDS words back-to-back.
// Backpr. : ready_out low from DECIDE through OUTPUTING; no output backpressure, the consumer takes every word.
//
// Ports:
//   clk_in, rst_in (async, active-low)
//   x_in, m_in, valid_in          : operand/modulus word stream, accepted when valid_in && ready_out
//   data_out, valid_out, final_out: result word stream, final_out marks the MSW
//   ready_out                     : high in IDLE and RECEIVING only
module conditional_modulus_subtractor #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 8192   // must be an exact multiple of REGISTER_SIZE
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [REGISTER_SIZE-1:0] x_in,
  input  logic [REGISTER_SIZE-1:0] m_in,
  input  logic                     valid_in,
  output logic [REGISTER_SIZE-1:0] data_out,
  output logic                     valid_out,
  output logic                     final_out,
  output logic                     ready_out
);

  localparam int NUM_WORDS = BITS_IN_NUM / REGISTER_SIZE;
  localparam int ADDR_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int CNT_W     = $clog2(NUM_WORDS + 1);

  localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0]  NUM_WORDS_C = CNT_W'(NUM_WORDS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECEIVING = 2'd1,
    DECIDE    = 2'd2,
    OUTPUTING = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        wr_idx_q, wr_idx_d;
  logic                     borrow_q, borrow_d;
  logic                     sel_q, sel_d;
  // Read address is one wider than the buffer index so it can reach NUM_WORDS
  // and mark the end of the read burst.
  logic [CNT_W-1:0]         rd_addr_q, rd_addr_d;
  logic                     rd_vld_q, rd_vld_d;
  logic                     rd_last_q, rd_last_d;
  logic [REGISTER_SIZE-1:0] data_out_q, data_out_d;
  logic                     valid_out_q, valid_out_d;
  logic                     final_out_q, final_out_d;

  logic [REGISTER_SIZE-1:0] xbuf [NUM_WORDS];
  logic [REGISTER_SIZE-1:0] dbuf [NUM_WORDS];
  logic [REGISTER_SIZE-1:0] rd_x_q, rd_d_q;

  logic                     accept;
  logic                     borrow_in;
  logic [REGISTER_SIZE:0]   diff;
  logic [ADDR_W-1:0]        rd_idx;

  assign ready_out = (state_q == IDLE) || (state_q == RECEIVING);
  assign accept    = valid_in && ready_out;

  // The first word of a frame always starts a fresh borrow chain.
  assign borrow_in = (state_q == IDLE) ? 1'b0 : borrow_q;
  assign diff      = {1'b0, x_in} - {1'b0, m_in} - {{REGISTER_SIZE{1'b0}}, borrow_in};
  assign rd_idx    = rd_addr_q[ADDR_W-1:0];

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    borrow_d    = borrow_q;
    sel_d       = sel_q;
    rd_addr_d   = rd_addr_q;
    rd_vld_d    = 1'b0;
    rd_last_d   = 1'b0;
    data_out_d  = '0;
    valid_out_d = 1'b0;
    final_out_d = 1'b0;

    case (state_q)
      IDLE, RECEIVING: begin
        if (state_q == IDLE) begin
          borrow_d = 1'b0;
        end
        if (accept) begin
          borrow_d = diff[REGISTER_SIZE];
          if (wr_idx_q == LAST_IDX) begin
            state_d  = DECIDE;
            wr_idx_d = '0;
          end else begin
            state_d  = RECEIVING;
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end

      DECIDE: begin
        // No final borrow means x >= m, so the difference buffer is the result.
        sel_d     = ~borrow_q;
        rd_vld_d  = 1'b1;                 // read of index 0 (rd_addr_q is 0 here)
        rd_last_d = (NUM_WORDS == 1);
        rd_addr_d = CNT_W'(1);
        state_d   = OUTPUTING;
      end

      OUTPUTING: begin
        data_out_d  = sel_q ? rd_d_q : rd_x_q;
        valid_out_d = rd_vld_q;
        final_out_d = rd_last_q;
        if (rd_addr_q < NUM_WORDS_C) begin
          rd_vld_d  = 1'b1;
          rd_last_d = (rd_addr_q == NUM_WORDS_C - CNT_W'(1));
          rd_addr_d = rd_addr_q + CNT_W'(1);
        end
        // Leave once the MSW is on the output, so ready_out returns with valid_out low.
        if (final_out_q) begin
          state_d   = IDLE;
          rd_addr_d = '0;
          borrow_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      wr_idx_q    <= '0;
      borrow_q    <= 1'b0;
      sel_q       <= 1'b0;
      rd_addr_q   <= '0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      final_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      borrow_q    <= borrow_d;
      sel_q       <= sel_d;
      rd_addr_q   <= rd_addr_d;
      rd_vld_q    <= rd_vld_d;
      rd_last_q   <= rd_last_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      final_out_q <= final_out_d;
    end
  end

  // Buffers: one write and one registered read port each, no reset on contents.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      xbuf[wr_idx_q] <= x_in;
      dbuf[wr_idx_q] <= diff[REGISTER_SIZE-1:0];
    end
    if (rd_vld_d) begin
      rd_x_q <= xbuf[rd_idx];
      rd_d_q <= dbuf[rd_idx];
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign final_out = final_out_q;

endmodule

// File: tb/tb_conditional_modulus_subtractor.sv
module tb_conditional_modulus_subtractor;

  localparam int W  = 32;
  localparam int BN = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [W-1:0] s_x, s_m, s_dat;
  logic         s_vld, s_vout, s_fin, s_rdy;
  logic [W-1:0] b_x, b_m, b_dat;
  logic         b_vld, b_vout, b_fin, b_rdy;

  int checks = 0;
  int errors = 0;

  conditional_modulus_subtractor #(.REGISTER_SIZE(32), .BITS_IN_NUM(128)) dut (
    .clk_in(clk), .rst_in(rst_n), .x_in(s_x), .m_in(s_m), .valid_in(s_vld),
    .data_out(s_dat), .valid_out(s_vout), .final_out(s_fin), .ready_out(s_rdy)
  );

  conditional_modulus_subtractor dut_big (
    .clk_in(clk), .rst_in(rst_n), .x_in(b_x), .m_in(b_m), .valid_in(b_vld),
    .data_out(b_dat), .valid_out(b_vout), .final_out(b_fin), .ready_out(b_rdy)
  );

  function automatic logic [127:0] pack4(input logic [31:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Sends one 4-word frame and checks the exact output timing and contents.
  // Entered and left at a negedge with the DUT in IDLE.
  task automatic run_small(input logic [127:0] x, input logic [127:0] m, input int gap,
                           input bit hold_garbage, input string name);
    logic [127:0] exp;
    exp = (x >= m) ? (x - m) : x;
    for (int i = 0; i < 4; i++) begin
      s_x = x[32*i +: 32];
      s_m = m[32*i +: 32];
      s_vld = 1'b1;
      checks++;
      if (s_rdy !== 1'b1) begin
        errors++;
        $display("FAIL %s ready_out word %0d: got %b want 1", name, i, s_rdy);
      end
      @(negedge clk);
      if (gap > 0 && i < 3) begin
        s_vld = 1'b0;
        s_x = $urandom;
        repeat (gap) @(negedge clk);
      end
    end
    if (hold_garbage) begin
      s_vld = 1'b1; s_x = $urandom; s_m = $urandom;
    end else begin
      s_vld = 1'b0;
    end
    checks++;
    if ({s_vout, s_rdy} !== 2'b00) begin
      errors++;
      $display("FAIL %s decide: got valid_out,ready_out=%b want 00", name, {s_vout, s_rdy});
    end
    @(negedge clk);
    checks++;
    if ({s_vout, s_rdy} !== 2'b00) begin
      errors++;
      $display("FAIL %s latency: got valid_out,ready_out=%b want 00", name, {s_vout, s_rdy});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (hold_garbage) begin
        s_x = $urandom; s_m = $urandom;
      end
      if (k == 3) s_vld = 1'b0;
      checks++;
      if ({s_vout, s_fin, s_rdy, s_dat} !== {1'b1, (k == 3), 1'b0, exp[32*k +: 32]}) begin
        errors++;
        $display("FAIL %s out word %0d: got vld=%b fin=%b rdy=%b dat=%h want vld=1 fin=%b rdy=0 dat=%h",
                 name, k, s_vout, s_fin, s_rdy, s_dat, (k == 3), exp[32*k +: 32]);
      end
    end
    @(negedge clk);
    checks++;
    if ({s_vout, s_fin, s_rdy} !== 3'b001) begin
      errors++;
      $display("FAIL %s end of frame: got vld,fin,rdy=%b want 001", name, {s_vout, s_fin, s_rdy});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_vld = 1'b0; s_x = '0; s_m = '0;
    b_vld = 1'b0; b_x = '0; b_m = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_vout, s_fin, s_dat, b_vout, b_fin, b_dat} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got small vld=%b fin=%b dat=%h big vld=%b fin=%b dat=%h want all 0",
               s_vout, s_fin, s_dat, b_vout, b_fin, b_dat);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_rdy, b_rdy, s_vout, b_vout} !== 4'b1100) begin
      errors++;
      $display("FAIL reset release: got rdy=%b%b vld=%b%b want rdy=11 vld=00", s_rdy, b_rdy, s_vout, b_vout);
    end
  endtask

  task automatic test_directed();
    run_small(pack4(5, 0, 0, 1), pack4(3, 0, 0, 1), 0, 1'b0, "x_ge_m");
    run_small(pack4(3, 0, 0, 1), pack4(5, 0, 0, 1), 0, 1'b0, "x_lt_m");
    run_small(pack4(0, 0, 0, 2), pack4(1, 0, 0, 1), 0, 1'b0, "borrow_chain");
  endtask

  task automatic test_equal_gapped();
    run_small(pack4(7, 7, 7, 7), pack4(7, 7, 7, 7), 0, 1'b0, "equal");
    run_small(pack4(7, 7, 7, 7), pack4(7, 7, 7, 7), 1, 1'b0, "equal_gapped");
  endtask

  task automatic test_back_to_back();
    run_small(pack4(32'hDEAD, 3, 0, 1), pack4(32'hBEEF, 2, 0, 1), 0, 1'b1, "garbage_hold");
    run_small(pack4(9, 0, 0, 0), pack4(4, 0, 0, 0), 0, 1'b0, "back_to_back");
  endtask

  task automatic test_reset_mid_frame();
    // Two words leaving borrow=1 and write index 2, then reset.
    for (int i = 0; i < 2; i++) begin
      s_x = 0; s_m = 1; s_vld = 1'b1;
      @(negedge clk);
    end
    s_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_vout, s_fin, s_dat} !== '0) begin
      errors++;
      $display("FAIL reset_receiving outputs: got vld=%b fin=%b dat=%h want 0", s_vout, s_fin, s_dat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_vout, s_rdy} !== 2'b01) begin
      errors++;
      $display("FAIL reset_receiving release: got vld,rdy=%b want 01", {s_vout, s_rdy});
    end
    run_small(pack4(6, 0, 0, 0), pack4(5, 0, 0, 0), 0, 1'b0, "after_reset_rx");

    // Reset while the result is streaming out.
    for (int i = 0; i < 4; i++) begin
      s_x = (i == 0) ? 32'd9 : 32'd1; s_m = (i == 0) ? 32'd4 : 32'd0; s_vld = 1'b1;
      @(negedge clk);
    end
    s_vld = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_vout, s_dat} !== {1'b1, 32'd5}) begin
      errors++;
      $display("FAIL reset_outputing pre: got vld=%b dat=%h want vld=1 dat=00000005", s_vout, s_dat);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_vout, s_fin, s_dat} !== '0) begin
      errors++;
      $display("FAIL reset_outputing outputs: got vld=%b fin=%b dat=%h want 0", s_vout, s_fin, s_dat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_small(pack4(3, 0, 0, 1), pack4(2, 0, 0, 1), 0, 1'b0, "after_reset_out");
  endtask

  task automatic test_random_small();
    logic [127:0] x, m;
    for (int n = 0; n < 20; n++) begin
      m = rand128();
      case ($urandom_range(0, 3))
        0: x = rand128();
        1: x = m;
        2: x = m + 128'($urandom_range(1, 3));
        default: x = m - 128'($urandom_range(1, 3));
      endcase
      run_small(x, m, $urandom_range(0, 2), 1'b0, "random_small");
    end
  endtask

  task automatic run_big(input logic [BN*W-1:0] x, input logic [BN*W-1:0] m, input string name);
    logic [BN*W-1:0] exp;
    int waited;
    exp = (x >= m) ? (x - m) : x;
    for (int i = 0; i < BN; i++) begin
      b_x = x[32*i +: 32];
      b_m = m[32*i +: 32];
      b_vld = 1'b1;
      @(negedge clk);
    end
    b_vld = 1'b0;
    waited = 0;
    while (b_vout !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited != 2) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles to valid_out want 2", name, waited);
    end
    if (b_vout === 1'b1) begin
      for (int k = 0; k < BN; k++) begin
        checks++;
        if ({b_vout, b_fin, b_dat} !== {1'b1, (k == BN - 1), exp[32*k +: 32]}) begin
          errors++;
          $display("FAIL %s word %0d: got vld=%b fin=%b dat=%h want vld=1 fin=%b dat=%h",
                   name, k, b_vout, b_fin, b_dat, (k == BN - 1), exp[32*k +: 32]);
        end
        @(negedge clk);
      end
      checks++;
      if ({b_vout, b_rdy} !== 2'b01) begin
        errors++;
        $display("FAIL %s end of frame: got vld,rdy=%b want 01", name, {b_vout, b_rdy});
      end
    end
  endtask

  task automatic test_full_size();
    logic [BN*W-1:0] x, m;
    for (int i = 0; i < BN; i++) begin
      x[32*i +: 32] = $urandom;
      m[32*i +: 32] = $urandom;
    end
    run_big(x, m, "full_a");
    run_big(m, x, "full_b");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_equal_gapped();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_small();
    test_full_size();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conditional_modulus_subtractor.md
Name: conditional_modulus_subtractor

Overview:
- Sits directly downstream of the candidate multiplier.
- Consumes its word-serial big-number result stream (LSW first) together with a word-aligned modulus stream.
- Computes x - m on the fly with a borrow chain, buffering both x and x - m.
- After the last word it selects x - m if x >= m, else x, and re-streams the result in the same word-serial format for the next stage.

Parameters:
- REGISTER_SIZE, 32, word width in bits.
- BITS_IN_NUM, 8192, operand width in bits. NUM_WORDS = BITS_IN_NUM/REGISTER_SIZE (256). Must divide exactly.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- x_in  input  REGISTER_SIZE  operand word (product stream), LSW first.
- m_in  input  REGISTER_SIZE  modulus word, aligned with x_in; the sender zero-pads above the modulus width.
- valid_in  input  1  x_in/m_in valid this cycle.
- data_out  output  REGISTER_SIZE  result word, LSW first.
- valid_out  output  1  data_out valid.
- final_out  output  1  high with the last (MSW) result word.
- ready_out  output  1  high only in IDLE and RECEIVING; input words are accepted only when valid_in && ready_out.

Behaviour:
- Reset (rst_in low, asynchronous): state=IDLE, word counter=0, borrow=0, data_out=0, valid_out=0, final_out=0, ready_out=1 from the first clock after deassertion. Buffer contents are not cleared and are don't-care.
- Storage: two NUM_WORDS x REGISTER_SIZE buffers, XBUF and DBUF, each 1 write port and 1 read port.
- State IDLE:
  - ready_out=1. The first accepted word is written to index 0 and the block moves to RECEIVING (or straight to DECIDE when NUM_WORDS==1).
  - borrow is cleared to 0 on entry.
- State RECEIVING:
  - ready_out=1. Each accepted word i is processed as follows:
    - {b, d} = {1'b0, x_in} - {1'b0, m_in} - borrow, computed at REGISTER_SIZE+1 bits.
    - XBUF[i] <= x_in; DBUF[i] <= d[REGISTER_SIZE-1:0]; borrow <= d[REGISTER_SIZE].
  - Gaps in valid_in are allowed: nothing changes while valid_in=0.
  - Accepting word NUM_WORDS-1 moves the block to DECIDE.
- State DECIDE (1 cycle):
  - ready_out=0. sel <= ~borrow, i.e. x >= m selects DBUF; x < m selects XBUF.
  - Read address is preset to 0, and the read of index 0 is issued this cycle.
- State OUTPUTING:
  - ready_out=0. valid_out=1 for exactly NUM_WORDS consecutive cycles.
  - data_out = sel ? DBUF[k] : XBUF[k] for k = 0..NUM_WORDS-1. Reads are registered with 1-cycle latency and the read address is pipelined ahead.
  - final_out=1 only together with k=NUM_WORDS-1.
  - The cycle after the last word: valid_out=0, final_out=0, state=IDLE, ready_out=1.
- Latency: first valid_out occurs 2 cycles after the clock edge that accepted the last input word.
- No output backpressure: the consumer must take every word.
- valid_in while ready_out=0: ignored, with no state change. A word presented in the same cycle IDLE is re-entered (ready_out=1) is accepted.
- Equal operands (x == m): borrow=0, so the output is all zero words.
- Modular wrap: the subtraction wraps modulo 2^BITS_IN_NUM internally. DBUF content is only ever output when no final borrow occurred.
- Reset asserted mid-RECEIVING or mid-OUTPUTING:
  - Outputs drop to 0 immediately (asynchronously). The partial frame is discarded.
  - The next frame starts at word index 0 with borrow=0.

Test Plan:
- BITS_IN_NUM=128 (4 words). x words (LSW first) = {5,0,0,1}, m = {3,0,0,1} -> output {2,0,0,0}; final_out on 4th word; first valid_out 2 cycles after 4th input.
- x={3,0,0,1}, m={5,0,0,1} -> final borrow=1, output = x = {3,0,0,1}.
- Borrow propagation: x={0,0,0,2}, m={1,0,0,1} -> output {FFFFFFFF,FFFFFFFF,FFFFFFFF,0}.
- x == m = {7,7,7,7} -> output {0,0,0,0}. Gapped valid_in (one idle cycle between each word) -> identical result, with ready_out low throughout DECIDE/OUTPUTING.
- valid_in held high during OUTPUTING with garbage data -> output unaffected. Next frame {9,0,0,0}-{4,0,0,0} accepted immediately after return to IDLE -> {5,0,0,0}.
- rst_in pulsed low after 2 input words -> valid_out=0 and ready_out=1 after release. A full new frame then yields the correct result (borrow not carried over). Default parameters: a 256-word random x, m frame matches the software reference (x >= m ? x - m : x).
